// File: rtl/xm_mem_responder_if.sv
// Memory request bus between the X-Makina controller (master) and the memory responder (slave).
interface xm_mem_responder_if #(
  parameter int unsigned WORD = 16
);
  logic            memEn_i;
  logic            memRW_i;
  logic            byteOp_i;
  logic [WORD-1:0] adr_i;
  logic [WORD-1:0] wrData_i;
  logic            memBusy_o;
  logic            memDone_o;
  logic [WORD-1:0] rdData_o;
  logic            memErr_o;

  // Controller side: issues requests, observes completion.
  modport master (
    output memEn_i, memRW_i, byteOp_i, adr_i, wrData_i,
    input  memBusy_o, memDone_o, rdData_o, memErr_o
  );

  // Responder side: accepts requests, reports completion.
  modport slave (
    input  memEn_i, memRW_i, byteOp_i, adr_i, wrData_i,
    output memBusy_o, memDone_o, rdData_o, memErr_o
  );
endinterface

// File: rtl/xm_mem_responder.sv
// Memory-side responder: word-organised RAM with byte/word access and programmable wait states.
module xm_mem_responder #(
  parameter int unsigned WORD        = 16,
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              clk_i,
  input  logic              arst_i,
  xm_mem_responder_if.slave bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Latched request; only the address bits that reach the RAM are kept.
  typedef struct packed {
    logic                rw;
    logic                byte_op;
    logic [DEPTH_LOG2:0] adr;
    logic [WORD-1:0]     wdata;
  } req_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  req_t                r_req;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [WORD-1:0]     r_rd;
  logic [WORD-1:0]     r_mem [DEPTH];

  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_hi;
  logic [WORD-1:0]       w_word;
  logic [7:0]            w_lane;
  logic [WORD-1:0]       w_rd_val;
  logic                  w_misalign;
  logic                  w_unused_adr;

  // Upper address bits are ignored, so the RAM aliases across the address space.
  assign w_unused_adr = ^bus.adr_i[WORD-1:DEPTH_LOG2+1];

  // Decode of the latched request: word index, lane select, read value, alignment.
  assign w_idx      = r_req.adr[DEPTH_LOG2:1];
  assign w_hi       = r_req.adr[0];
  assign w_word     = r_mem[w_idx];
  assign w_lane     = w_hi ? w_word[15:8] : w_word[7:0];
  assign w_rd_val   = r_req.byte_op ? {(WORD-8)'(0), w_lane} : w_word;
  assign w_misalign = ~r_req.byte_op & r_req.adr[0];

  // Request FSM with registered busy/done/err/read-data outputs.
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_req   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rd    <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.memEn_i) begin
            r_req <= '{rw:      bus.memRW_i,
                       byte_op: bus.byteOp_i,
                       adr:     bus.adr_i[DEPTH_LOG2:0],
                       wdata:   bus.wrData_i};
            r_cnt  <= CW'(WAIT_STATES);
            r_busy <= 1'b1;
            if (WAIT_STATES == 0) begin
              r_state <= ACCESS;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          // Counter was loaded with WAIT_STATES; the cycle it reads 1 is the last wait cycle.
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt <= CW'(1)) begin
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_err   <= w_misalign;
          if (!r_req.rw) begin
            r_rd <= w_rd_val;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // RAM write port; commits only in ACCESS, so a reset during WAIT drops the write.
  always_ff @(posedge clk_i) begin
    if (r_state == ACCESS && r_req.rw) begin
      if (r_req.byte_op) begin
        if (w_hi) begin
          r_mem[w_idx][15:8] <= r_req.wdata[7:0];
        end else begin
          r_mem[w_idx][7:0]  <= r_req.wdata[7:0];
        end
      end else begin
        r_mem[w_idx] <= r_req.wdata;
      end
    end
  end

  assign bus.memBusy_o = r_busy;
  assign bus.memDone_o = r_done;
  assign bus.memErr_o  = r_err;
  assign bus.rdData_o  = r_rd;

endmodule
